// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives an external 1-bit full adder LSB first
// and assembles the WIDTH-bit sum plus final carry, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; previous result held on sum/cout
// RUN   | one operand bit per cycle through the external full adder
// DONE  | result valid, done pulsed for one cycle
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Concatenate-then-drop keeps the shift legal for WIDTH == 1.
    logic [WIDTH:0]   sum_ext;
    assign sum_ext = {fa_s, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum_sh_d = sum_ext[WIDTH:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign fa_a   = busy & a_sh_q[0];
    assign fa_b   = busy & b_sh_q[0];
    assign fa_cin = busy & carry_q;
    assign sum    = sum_sh_q;
    assign cout   = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1,
// each instance wired to a behavioural full adder.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in, b_in;
    logic       cin;
    logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       cin1;
    logic       fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
    logic       busy1, done1, cout1;

    int  checks = 0;
    int  errors = 0;
    time last_acc = 0;
    bit  have_acc = 0;

    always #5 clk = ~clk;

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    serial_add_ctrl #(.WIDTH(8), .CNT_W(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1), .CNT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition on the WIDTH=8 instance; hold keeps start high with new
    // operands during RUN to show the second request is ignored.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input bit hold, input bit chk_sp,
                           output logic [7:0] s_o, output logic c_o);
        int   busy_n;
        int   done_at;
        logic prev_c;
        busy_n  = 0;
        done_at = -1;
        a_in = a; b_in = b; cin = ci; start = 1'b1;
        @(posedge clk);
        if (chk_sp && have_acc) check("start_spacing", 64'($time - last_acc), 64'd100);
        last_acc = $time;
        have_acc = 1'b1;
        #1;
        if (hold) begin
            a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
        end else begin
            start = 1'b0;
        end
        prev_c = ci;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                done_at = i;
                break;
            end
            if (busy) begin
                check("fa_cin_chain", 64'(fa_cin), 64'(prev_c));
                prev_c = fa_cout;
                busy_n++;
            end
        end
        start = 1'b0;
        check("done_latency", 64'(done_at), 64'd8);
        check("busy_cycles", 64'(busy_n), 64'd8);
        s_o = sum;
        c_o = cout;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] s;
        logic       c;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp9;
        int         ndone;

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Inputs toggling in IDLE must not reach the adder pins.
        a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_fa8", 64'({fa_a, fa_b, fa_cin}), 64'd0);
            check("idle_fa1", 64'({fa_a1, fa_b1, fa_cin1}), 64'd0);
        end

        run_add(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, s, c);
        check("5a_3c_sum", 64'(s), 64'h96);
        check("5a_3c_cout", 64'(c), 64'd0);

        run_add(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, s, c);
        check("ff_01_sum", 64'(s), 64'h00);
        check("ff_01_cout", 64'(c), 64'd1);

        run_add(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, s, c);
        check("ff_ff_1_sum", 64'(s), 64'hFF);
        check("ff_ff_1_cout", 64'(c), 64'd1);

        run_add(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, s, c);
        check("held_start_sum", 64'(s), 64'h46);
        check("held_start_cout", 64'(c), 64'd0);
        @(negedge clk);
        check("sum_held_idle", 64'(sum), 64'h46);
        check("no_restart", 64'(busy), 64'd0);

        run_add(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, s, c);
        check("aa_55_sum", 64'(s), 64'hFF);
        check("aa_55_cout", 64'(c), 64'd0);

        // Reset during the fourth RUN cycle.
        a_in = 8'h80; b_in = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no_done_after_rst", 64'(ndone), 64'd0);

        run_add(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, s, c);
        check("01_01_sum", 64'(s), 64'h02);
        check("01_01_cout", 64'(c), 64'd0);

        // WIDTH=1 instance: 1+1+1 = 0b11.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        check("w1_busy", 64'(busy1), 64'd1);
        check("w1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        check("w1_busy_end", 64'(busy1), 64'd0);
        check("w1_done", 64'(done1), 64'd1);
        check("w1_sum", 64'(sum1), 64'd1);
        check("w1_cout", 64'(cout1), 64'd1);
        @(negedge clk);
        check("w1_done_pulse", 64'(done1), 64'd0);
        check("w1_idle_fa", 64'({fa_a1, fa_b1, fa_cin1}), 64'd0);

        // Back-to-back random regression.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_add(ra, rb, rc, 1'b0, (k > 0), s, c);
            check("rand_result", 64'({c, s}), 64'(exp9));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
